// File: rtl/udiv32_seq_ctrl.sv
// Sequential 32-bit unsigned divider: one non-restoring step per clock, then a restore fix-up.
// Optional UDIV_DIVZERO_TRAP_EN: a zero divisor skips the iterations and completes in one cycle.
module udiv32_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic        Abort,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Quotient,
    output logic [31:0] Remainder,
    output logic        DivByZero
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [32:0] r_q;
    logic [32:0] d_q;
    logic [31:0] q_q;
    logic        busy_q;
    logic        done_q;
    logic        dbz_q;
    logic [31:0] quot_q;
    logic [31:0] rem_q;

    logic [32:0] r_sh;
    logic [32:0] r_iter_d;
    logic [32:0] r_fix_d;

    // The sign of the old partial remainder picks add or subtract; bit 32 carries it.
    always_comb begin
        r_sh     = {r_q[31:0], q_q[31]};
        r_iter_d = r_q[32] ? (r_sh + d_q) : (r_sh - d_q);
        r_fix_d  = r_q[32] ? (r_q + d_q) : r_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            r_q     <= 33'd0;
            d_q     <= 33'd0;
            q_q     <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        d_q     <= {1'b0, Divisor};
                        q_q     <= Dividend;
                        r_q     <= 33'd0;
                        cnt_q   <= 5'd31;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ITER;
`ifdef UDIV_DIVZERO_TRAP_EN
                        if (Divisor == 32'd0) begin
                            quot_q  <= 32'hFFFF_FFFF;
                            rem_q   <= Dividend;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
`endif
                    end
                end
                ITER: begin
                    if (Abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        r_q <= r_iter_d;
                        q_q <= {q_q[30:0], ~r_iter_d[32]};
                        if (cnt_q == 5'd0) begin
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                FIX: begin
                    if (Abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        r_q     <= r_fix_d;
                        quot_q  <= q_q;
                        rem_q   <= r_fix_d[31:0];
                        dbz_q   <= (d_q == 33'd0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_udiv32_seq_ctrl.sv
// Bench for udiv32_seq_ctrl: cycle-indexed reference model plus directed and random divisions.
// Build with +define+UDIV_DIVZERO_TRAP_EN to check the trap variant.
module tb_udiv32_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic [31:0] Dividend = 32'd0;
    logic [31:0] Divisor = 32'd0;
    logic        Busy;
    logic        Done;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        DivByZero;

    int total = 0;
    int bad = 0;

`ifdef UDIV_DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    udiv32_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Abort(Abort),
        .Dividend(Dividend), .Divisor(Divisor), .Busy(Busy), .Done(Done),
        .Quotient(Quotient), .Remainder(Remainder), .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_cyc is the cycle number within the current division (0 = idle).
    int          m_cyc = 0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0, m_q = 32'd0, m_r = 32'd0;
    logic        m_z = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0; m_a <= '0; m_b <= '0; m_q <= '0; m_r <= '0; m_z <= 1'b0;
        end else if (m_cyc == 0) begin
            if (Start) begin
                m_a <= Dividend; m_b <= Divisor; m_z <= 1'b0; m_cyc <= 1;
                if (TRAP && Divisor == 32'd0) begin
                    m_cyc <= 34; m_q <= 32'hFFFF_FFFF; m_r <= Dividend; m_z <= 1'b1;
                end
            end
        end else if (m_cyc == 34) begin
            m_cyc <= 0;
        end else if (Abort) begin
            m_cyc <= 0;
        end else begin
            if (m_cyc == 33) begin
                m_q <= (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
                m_r <= (m_b == 0) ? m_a : m_a % m_b;
                m_z <= (m_b == 0);
            end
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        cmp("busy", {31'd0, Busy}, {31'd0, m_cyc != 0});
        cmp("done", {31'd0, Done}, {31'd0, m_cyc == 34});
        cmp("quotient", Quotient, m_q);
        cmp("remainder", Remainder, m_r);
        cmp("divbyzero", {31'd0, DivByZero}, {31'd0, m_z});
    end

    // Launch one division in cycle 0 and observe cycles 1..40; extra Start/Abort pulses at given cycles.
    task automatic div(input logic [31:0] a, input logic [31:0] b, input int s1, input int s2,
                       input int ab, output int dcyc, output int nd);
        @(posedge clk); #2;
        Dividend = a; Divisor = b; Start = 1'b1; Abort = 1'b0;
        dcyc = -1; nd = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #2;
            Start = (n == s1) || (n == s2);
            Abort = (n == ab);
            Dividend = $urandom; Divisor = $urandom;
            if (Done) begin
                nd++;
                if (dcyc < 0) dcyc = n;
            end
        end
        Start = 1'b0; Abort = 1'b0;
    endtask

    int dc, nd, lat0;

    initial begin
        #12;
        cmp("reset_busy", {31'd0, Busy}, 32'd0);
        cmp("reset_quot", Quotient, 32'd0);
        #11 rst_n = 1'b1;

        div(32'd100, 32'd7, 0, 0, 0, dc, nd);
        cmp("lat_100_7", dc, 34);
        cmp("q_100_7", Quotient, 32'd14);
        cmp("r_100_7", Remainder, 32'd2);
        cmp("z_100_7", {31'd0, DivByZero}, 32'd0);

        div(32'hFFFF_FFFF, 32'd1, 0, 0, 0, dc, nd);
        cmp("q_max_1", Quotient, 32'hFFFF_FFFF);
        cmp("r_max_1", Remainder, 32'd0);
        div(32'd5, 32'd10, 0, 0, 0, dc, nd);
        cmp("q_5_10", Quotient, 32'd0);
        cmp("r_5_10", Remainder, 32'd5);

        div(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, dc, nd);
        cmp("q_sign", Quotient, 32'd0);
        cmp("r_sign", Remainder, 32'h8000_0000);

        div(32'h1234, 32'd0, 0, 0, 0, dc, nd);
        lat0 = TRAP ? 1 : 34;
        cmp("lat_div0", dc, lat0);
        cmp("q_div0", Quotient, 32'hFFFF_FFFF);
        cmp("r_div0", Remainder, 32'h1234);
        cmp("z_div0", {31'd0, DivByZero}, 32'd1);

        div(32'd1000, 32'd7, 5, 34, 0, dc, nd);
        cmp("ndone_ignored_start", nd, 1);
        cmp("q_1000_7", Quotient, 32'd142);
        cmp("r_1000_7", Remainder, 32'd6);

        div(32'd77, 32'd5, 0, 0, 20, dc, nd);
        cmp("ndone_abort", nd, 0);
        cmp("q_after_abort", Quotient, 32'd142);
        cmp("r_after_abort", Remainder, 32'd6);

        // Asynchronous reset in cycle 15 of a division.
        @(posedge clk); #2;
        Dividend = 32'd1000; Divisor = 32'd3; Start = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk); #2;
            Start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        cmp("rst_busy", {31'd0, Busy}, 32'd0);
        cmp("rst_done", {31'd0, Done}, 32'd0);
        cmp("rst_quot", Quotient, 32'd0);
        cmp("rst_rem", Remainder, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        nd = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #2;
            if (Done) nd++;
        end
        cmp("ndone_after_rst", nd, 0);
        div(32'd200, 32'd9, 0, 0, 0, dc, nd);
        cmp("q_200_9", Quotient, 32'd22);
        cmp("r_200_9", Remainder, 32'd2);

        for (int i = 0; i < 50; i++) begin
            logic [31:0] a, b;
            int s1, s2, ab, expn;
            bit ztrap;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = $urandom;
                default: b = a >> $urandom_range(0, 31);
            endcase
            ztrap = TRAP && (b == 32'd0);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
            s1 = 0; s2 = 0;
            if (!ztrap && ab == 0) begin
                s1 = $urandom_range(1, 34);
                s2 = $urandom_range(1, 34);
            end
            div(a, b, s1, s2, ab, dc, nd);
            expn = (!ztrap && ab >= 1 && ab <= 33) ? 0 : 1;
            cmp("rand_ndone", nd, expn);
            if (expn == 1) cmp("rand_latency", dc, ztrap ? 1 : 34);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
